// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch-stage sequencer.
// The package carries the state encoding and the default datapath width.
package fetch_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer between the PC register and a variable-latency instruction memory.
// It buffers a fetched word across decode stalls and discards responses that a redirect has orphaned.
import fetch_pkg::*;

module fetch_ctrl #(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            i_Clk,
    input  logic            i_Reset,
    input  logic [XLEN-1:0] i_PCF,
    input  logic            i_StallD,
    input  logic            i_Redirect,
    output logic            o_StallF,
    output logic            o_IMemReq,
    output logic [XLEN-1:0] o_IMemAddr,
    input  logic            i_IMemAck,
    input  logic [XLEN-1:0] i_IMemRData,
    output logic [XLEN-1:0] o_InstrF,
    output logic            o_InstrValidF
);

    fetch_state_t    r_State;
    fetch_state_t    w_NextState;
    logic [XLEN-1:0] r_Addr;
    logic [XLEN-1:0] r_Instr;
    logic            w_CaptureInstr;

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            r_State <= IDLE;
            r_Addr  <= '0;
            r_Instr <= '0;
        end else begin
            r_State <= w_NextState;
            // r_Addr tracks the live request so DROP can keep presenting it after the PC moves on
            if (r_State == REQ) begin
                r_Addr <= i_PCF;
            end
            if (w_CaptureInstr) begin
                r_Instr <= i_IMemRData;
            end
        end
    end

    always_comb begin
        w_NextState    = r_State;
        w_CaptureInstr = 1'b0;
        o_StallF       = 1'b1;
        o_IMemReq      = 1'b0;
        o_IMemAddr     = r_Addr;
        o_InstrF       = '0;
        o_InstrValidF  = 1'b0;

        unique case (r_State)
            IDLE: begin
                w_NextState = REQ;
            end

            REQ: begin
                o_IMemReq  = 1'b1;
                o_IMemAddr = i_PCF;
                if (i_Redirect) begin
                    // An outstanding request must still complete; only a same-cycle ack lets us skip DROP
                    o_StallF    = 1'b0;
                    w_NextState = i_IMemAck ? REQ : DROP;
                end else if (i_IMemAck) begin
                    o_InstrF      = i_IMemRData;
                    o_InstrValidF = 1'b1;
                    if (i_StallD) begin
                        w_CaptureInstr = 1'b1;
                        w_NextState    = HOLD;
                    end else begin
                        o_StallF = 1'b0;
                    end
                end
            end

            HOLD: begin
                o_InstrF      = r_Instr;
                o_InstrValidF = ~i_Redirect;
                if (i_Redirect || !i_StallD) begin
                    o_StallF    = 1'b0;
                    w_NextState = REQ;
                end
            end

            DROP: begin
                o_IMemReq  = 1'b1;
                o_IMemAddr = r_Addr;
                o_StallF   = ~i_Redirect;
                if (i_IMemAck) begin
                    w_NextState = REQ;
                end
            end

            default: begin
                w_NextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl: the bench plays both the PC register and the instruction memory.
// Inputs change on the falling edge and outputs are checked 1ns later, well clear of the rising edge.
module tb_fetch_ctrl;

    localparam int XLEN = 32;

    logic            i_Clk;
    logic            i_Reset;
    logic [XLEN-1:0] i_PCF;
    logic            i_StallD;
    logic            i_Redirect;
    logic            o_StallF;
    logic            o_IMemReq;
    logic [XLEN-1:0] o_IMemAddr;
    logic            i_IMemAck;
    logic [XLEN-1:0] i_IMemRData;
    logic [XLEN-1:0] o_InstrF;
    logic            o_InstrValidF;

    int vecCount  = 0;
    int missCount = 0;

    fetch_ctrl #(.XLEN(XLEN)) dut (
        .i_Clk        (i_Clk),
        .i_Reset      (i_Reset),
        .i_PCF        (i_PCF),
        .i_StallD     (i_StallD),
        .i_Redirect   (i_Redirect),
        .o_StallF     (o_StallF),
        .o_IMemReq    (o_IMemReq),
        .o_IMemAddr   (o_IMemAddr),
        .i_IMemAck    (i_IMemAck),
        .i_IMemRData  (i_IMemRData),
        .o_InstrF     (o_InstrF),
        .o_InstrValidF(o_InstrValidF)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                               input logic [XLEN-1:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Addresses are only meaningful while a request is up, instructions only while valid or buffered.
    task automatic checkAll(input string tag, input logic expReq, input logic [XLEN-1:0] expAddr,
                            input logic expValid, input logic [XLEN-1:0] expInstr,
                            input logic expStallF, input logic chkInstr);
        checkOutput({tag, ".req"},    {31'd0, o_IMemReq},     {31'd0, expReq});
        checkOutput({tag, ".valid"},  {31'd0, o_InstrValidF}, {31'd0, expValid});
        checkOutput({tag, ".stallF"}, {31'd0, o_StallF},      {31'd0, expStallF});
        if (expReq) checkOutput({tag, ".addr"}, o_IMemAddr, expAddr);
        if (chkInstr) checkOutput({tag, ".instr"}, o_InstrF, expInstr);
    endtask

    task automatic applyStimulus(input logic [XLEN-1:0] pc, input logic stallD, input logic redirect,
                                 input logic ack, input logic [XLEN-1:0] rdata);
        @(negedge i_Clk);
        i_PCF       = pc;
        i_StallD    = stallD;
        i_Redirect  = redirect;
        i_IMemAck   = ack;
        i_IMemRData = rdata;
        #1;
    endtask

    initial begin
        i_Reset     = 1'b0;
        i_PCF       = '0;
        i_StallD    = 1'b0;
        i_Redirect  = 1'b0;
        i_IMemAck   = 1'b0;
        i_IMemRData = '0;

        // reset state
        repeat (2) @(posedge i_Clk);
        #1;
        checkAll("reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);

        // release: one IDLE cycle, then zero-wait back-to-back fetch
        @(negedge i_Clk);
        i_Reset = 1'b1;
        #1;
        checkAll("idle", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1, 32'h1111_0000);
        checkAll("b2b0", 1'b1, 32'h0, 1'b1, 32'h1111_0000, 1'b0, 1'b1);
        applyStimulus(32'h4, 1'b0, 1'b0, 1'b1, 32'h1111_0004);
        checkAll("b2b4", 1'b1, 32'h4, 1'b1, 32'h1111_0004, 1'b0, 1'b1);
        applyStimulus(32'h8, 1'b0, 1'b0, 1'b1, 32'h1111_0008);
        checkAll("b2b8", 1'b1, 32'h8, 1'b1, 32'h1111_0008, 1'b0, 1'b1);

        // three wait cycles then ack
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h10, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
            checkAll("wait10", 1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 1'b0);
        end
        applyStimulus(32'h10, 1'b0, 1'b0, 1'b1, 32'h2222_0010);
        checkAll("ack10", 1'b1, 32'h10, 1'b1, 32'h2222_0010, 1'b0, 1'b1);

        // ack under decode stall, buffered in HOLD
        applyStimulus(32'h20, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);
        checkAll("ack20stall", 1'b1, 32'h20, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
        applyStimulus(32'h20, 1'b1, 1'b0, 1'b0, 32'h0BAD_0BAD);
        checkAll("hold", 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
        applyStimulus(32'h20, 1'b0, 1'b0, 1'b0, 32'h0BAD_0BAD);
        checkAll("holdrel", 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);

        // redirect while a request is pending: DROP keeps the old address
        applyStimulus(32'h30, 1'b0, 1'b0, 1'b0, 32'h0);
        checkAll("req30", 1'b1, 32'h30, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(32'h30, 1'b0, 1'b1, 1'b0, 32'h0);
        checkAll("redir30", 1'b1, 32'h30, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
        checkAll("drop", 1'b1, 32'h30, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(32'h100, 1'b0, 1'b0, 1'b1, 32'hBAD0_0030);
        checkAll("dropack", 1'b1, 32'h30, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(32'h100, 1'b0, 1'b0, 1'b1, 32'h3333_0100);
        checkAll("req100", 1'b1, 32'h100, 1'b1, 32'h3333_0100, 1'b0, 1'b1);

        // redirect coinciding with ack, then redirect overriding a stall in HOLD
        applyStimulus(32'h104, 1'b0, 1'b1, 1'b1, 32'hBAD0_0104);
        checkAll("redirack", 1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(32'h200, 1'b1, 1'b0, 1'b1, 32'h4444_0200);
        checkAll("ack200stall", 1'b1, 32'h200, 1'b1, 32'h4444_0200, 1'b1, 1'b1);
        applyStimulus(32'h200, 1'b1, 1'b1, 1'b0, 32'h0);
        checkAll("holdredir", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(32'h300, 1'b0, 1'b0, 1'b1, 32'h5555_0300);
        checkAll("req300", 1'b1, 32'h300, 1'b1, 32'h5555_0300, 1'b0, 1'b1);

        // reset asserted while in DROP
        applyStimulus(32'h304, 1'b0, 1'b1, 1'b0, 32'h0);
        checkAll("redir304", 1'b1, 32'h304, 1'b0, 32'h0, 1'b0, 1'b0);
        applyStimulus(32'h400, 1'b0, 1'b0, 1'b0, 32'h0);
        checkAll("drop304", 1'b1, 32'h304, 1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge i_Clk);
        i_Reset = 1'b0;
        #1;
        checkAll("midreset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        @(negedge i_Clk);
        i_PCF     = 32'h0;
        i_IMemAck = 1'b0;
        i_Reset   = 1'b1;
        #1;
        checkAll("idle2", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1, 32'h6666_0000);
        checkAll("restart", 1'b1, 32'h0, 1'b1, 32'h6666_0000, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
